// File: rtl/controle_tempo_rodada_pkg.sv
// -----------------------------------------------------------------------------
// controle_tempo_rodada_pkg
// Shared definitions for the round-timing sequencer:
//   - estado_t     : sequencer state encoding (also exported on db_estado)
//   - DB_ESTADO_W  : width of the debug state bus
//   - ultima_rodada: true when a round index is the last round of a game
// The PAUSA code is reserved in the encoding even when the pause feature
// (macro PAUSA_EN) is not built, so debug decoders never change.
// -----------------------------------------------------------------------------
package controle_tempo_rodada_pkg;

    localparam int DB_ESTADO_W = 3;

    typedef enum logic [DB_ESTADO_W-1:0] {
        INICIAL   = 3'd0,
        PREPARA   = 3'd1,
        CONTANDO  = 3'd2,
        PAUSA     = 3'd3,
        RESULTADO = 3'd4,
        FIM_JOGO  = 3'd5
    } estado_t;

    // Rounds are 0-based, so the last one is num_rodadas-1.
    function automatic logic ultima_rodada(input int rodada, input int num_rodadas);
        return (rodada == (num_rodadas - 1));
    endfunction

endpackage

// File: rtl/controle_tempo_rodada_if.sv
// -----------------------------------------------------------------------------
// controle_tempo_rodada_if
// Bundles the control/status signals between the game FSM, the time counter
// and the round sequencer.
//   master modport (game FSM / counter side):
//     out: iniciar, pausar, resposta_valida, proxima, fim_contador, meio_contador
//     in : zera_contador, conta_contador, rodada[R], alerta, timeout, no_prazo,
//          fim_jogo, db_estado[3]
//   slave modport (sequencer side): the same signals with directions reversed.
// Parameter R: width of the round index.
// -----------------------------------------------------------------------------
interface controle_tempo_rodada_if
    import controle_tempo_rodada_pkg::*;
#(
    parameter int R = 4
);

    // Requests from the game FSM and status from the time counter
    logic                   iniciar;
    logic                   pausar;
    logic                   resposta_valida;
    logic                   proxima;
    logic                   fim_contador;
    logic                   meio_contador;

    // Counter control and round status produced by the sequencer
    logic                   zera_contador;
    logic                   conta_contador;
    logic [R-1:0]           rodada;
    logic                   alerta;
    logic                   timeout;
    logic                   no_prazo;
    logic                   fim_jogo;
    logic [DB_ESTADO_W-1:0] db_estado;

    modport master (
        output iniciar,
        output pausar,
        output resposta_valida,
        output proxima,
        output fim_contador,
        output meio_contador,
        input  zera_contador,
        input  conta_contador,
        input  rodada,
        input  alerta,
        input  timeout,
        input  no_prazo,
        input  fim_jogo,
        input  db_estado
    );

    modport slave (
        input  iniciar,
        input  pausar,
        input  resposta_valida,
        input  proxima,
        input  fim_contador,
        input  meio_contador,
        output zera_contador,
        output conta_contador,
        output rodada,
        output alerta,
        output timeout,
        output no_prazo,
        output fim_jogo,
        output db_estado
    );

endinterface

// File: rtl/controle_tempo_rodada_divisor_tick.sv
// -----------------------------------------------------------------------------
// divisor_tick
// Prescaler that turns the system clock into a one-cycle counting tick every
// CLK_DIV enabled cycles.
// Ports:
//   clock  in  system clock (rising edge)
//   reset  in  asynchronous active-high reset, clears the prescaler
//   zera   in  synchronous clear of the prescaler (has priority over conta)
//   conta  in  advance enable; when low the prescaler holds its value
//   tick   out high in the enabled cycle where the prescaler is at CLK_DIV-1
// Parameter CLK_DIV (>=2): enabled cycles per tick.
// -----------------------------------------------------------------------------
module divisor_tick #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic tick
);

    localparam int         W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] ULTIMO = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_no_ultimo;

    assign w_no_ultimo = (r_cnt == ULTIMO);

    // Holding (rather than clearing) when conta is low is what keeps the
    // tick phase intact across a pause.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (zera) begin
            r_cnt <= '0;
        end else if (conta) begin
            r_cnt <= w_no_ultimo ? '0 : r_cnt + W'(1);
        end
    end

    assign tick = conta & w_no_ultimo;

endmodule

// File: rtl/controle_tempo_rodada.sv
// -----------------------------------------------------------------------------
// controle_tempo_rodada
// Round sequencer for the game-time counter (modulo-M counter with
// zera_s/conta/fim/meio). Clears and enables the counter once per round,
// generates the counting tick, detects timeout or an in-time answer, advances
// the round index and flags the end of the game.
//
// Ports:
//   clock  in   system clock, all logic on rising edge
//   reset  in   asynchronous active-high reset
//   bus    slave modport of controle_tempo_rodada_if:
//            in : iniciar, pausar, resposta_valida, proxima,
//                 fim_contador, meio_contador
//            out: zera_contador, conta_contador, rodada[R], alerta,
//                 timeout, no_prazo, fim_jogo, db_estado[3]
// Parameters:
//   CLK_DIV      clock cycles per counting tick (>=2)
//   NUM_RODADAS  rounds per game (>=1)
//   R            width of rodada (2**R >= NUM_RODADAS)
// Build option:
//   PAUSA_EN     when defined, pausar toggles CONTANDO <-> PAUSA; when not
//                defined the PAUSA state is never entered and pausar is ignored.
// -----------------------------------------------------------------------------
module controle_tempo_rodada
    import controle_tempo_rodada_pkg::*;
#(
    parameter int CLK_DIV     = 50_000_000,
    parameter int NUM_RODADAS = 10,
    parameter int R           = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    controle_tempo_rodada_if.slave  bus
);

    // State and registered outputs
    estado_t      r_estado;
    logic [R-1:0] r_rodada;
    logic         r_alerta;
    logic         r_timeout;
    logic         r_no_prazo;

    // Next-state values
    estado_t      w_estado_next;
    logic [R-1:0] w_rodada_next;
    logic         w_alerta_next;
    logic         w_timeout_next;
    logic         w_no_prazo_next;

    // Prescaler control
    logic         w_div_zera;
    logic         w_div_conta;
    logic         w_tick;

`ifndef PAUSA_EN
    // Without the pause feature the request is deliberately left unconnected.
    logic         w_unused_pausar;
    assign w_unused_pausar = bus.pausar;
`endif

    // -------------------------------------------------------------------------
    // Prescaler: runs only while the round is counting, cleared with the
    // counter at the start of every round.
    // -------------------------------------------------------------------------
    assign w_div_zera  = (r_estado == PREPARA);
    assign w_div_conta = (r_estado == CONTANDO);

    divisor_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_divisor_tick (
        .clock (clock),
        .reset (reset),
        .zera  (w_div_zera),
        .conta (w_div_conta),
        .tick  (w_tick)
    );

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_estado_next   = r_estado;
        w_rodada_next   = r_rodada;
        w_alerta_next   = r_alerta;
        w_timeout_next  = 1'b0;
        w_no_prazo_next = 1'b0;

        case (r_estado)
            INICIAL: begin
                if (bus.iniciar) begin
                    w_rodada_next = '0;
                    w_estado_next = PREPARA;
                end
            end

            PREPARA: begin
                // Counter is being cleared this cycle; half-time flag restarts.
                w_alerta_next = 1'b0;
                w_estado_next = CONTANDO;
            end

            CONTANDO: begin
                if (bus.meio_contador) begin
                    w_alerta_next = 1'b1;
                end
                // An answer arriving in the very cycle the counter expires
                // still counts as in time.
                if (bus.resposta_valida) begin
                    w_no_prazo_next = 1'b1;
                    w_estado_next   = RESULTADO;
                end else if (bus.fim_contador) begin
                    w_timeout_next = 1'b1;
                    w_estado_next  = RESULTADO;
                end
`ifdef PAUSA_EN
                else if (bus.pausar) begin
                    w_estado_next = PAUSA;
                end
`endif
            end

`ifdef PAUSA_EN
            PAUSA: begin
                if (bus.pausar) begin
                    w_estado_next = CONTANDO;
                end
            end
`endif

            RESULTADO: begin
                if (bus.proxima) begin
                    if (ultima_rodada(int'(r_rodada), NUM_RODADAS)) begin
                        w_estado_next = FIM_JOGO;
                    end else begin
                        w_rodada_next = r_rodada + R'(1);
                        w_estado_next = PREPARA;
                    end
                end
            end

            FIM_JOGO: begin
                if (bus.iniciar) begin
                    w_rodada_next = '0;
                    w_estado_next = PREPARA;
                end
            end

            default: begin
                // Unused codes (and PAUSA when not built) fall back to idle.
                w_estado_next = INICIAL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_rodada   <= '0;
            r_alerta   <= 1'b0;
            r_timeout  <= 1'b0;
            r_no_prazo <= 1'b0;
        end else begin
            r_estado   <= w_estado_next;
            r_rodada   <= w_rodada_next;
            r_alerta   <= w_alerta_next;
            r_timeout  <= w_timeout_next;
            r_no_prazo <= w_no_prazo_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // PREPARA always lasts exactly one cycle, so the clear is a single pulse.
    assign bus.zera_contador  = (r_estado == PREPARA);
    // Suppressing the tick at fim keeps the counter parked at M-1 instead of
    // wrapping during the cycle the timeout is being registered.
    assign bus.conta_contador = w_tick & ~bus.fim_contador;
    assign bus.rodada         = r_rodada;
    assign bus.alerta         = r_alerta;
    assign bus.timeout        = r_timeout;
    assign bus.no_prazo       = r_no_prazo;
    assign bus.fim_jogo       = (r_estado == FIM_JOGO);
    assign bus.db_estado      = r_estado;

endmodule

// File: tb/tb_controle_tempo_rodada.sv
`timescale 1ns/1ps
module tb_controle_tempo_rodada;
    import controle_tempo_rodada_pkg::*;

    localparam int CLK_DIV     = 4;
    localparam int NUM_RODADAS = 3;
    localparam int R           = 2;
    localparam int M           = 8;
    // Active counting cycles after which the counter reaches M-1 / M/2-1.
    localparam int J_FIM  = (M - 1) * CLK_DIV;
    localparam int J_MEIO = (M / 2 - 1) * CLK_DIV;
`ifdef PAUSA_EN
    localparam bit PAUSA_ATIVA = 1'b1;
`else
    localparam bit PAUSA_ATIVA = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    controle_tempo_rodada_if #(.R(R)) bus();

    controle_tempo_rodada #(
        .CLK_DIV     (CLK_DIV),
        .NUM_RODADAS (NUM_RODADAS),
        .R           (R)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Time counter modulo M (not reset by the system reset).
    logic [2:0] q = 3'd0;
    always @(posedge clock) begin
        if (bus.zera_contador)       q <= 3'd0;
        else if (bus.conta_contador) q <= q + 3'd1;
    end
    assign bus.fim_contador  = (q == 3'(M - 1));
    assign bus.meio_contador = (q == 3'(M / 2 - 1));

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard
    typedef struct {
        int          kind;   // 0 no_prazo, 1 timeout, 2 fim_jogo
        int unsigned cyc;
        int          rodada;
        int          alerta;
        int          q;
    } evt_t;
    evt_t        exp_q[$];
    int unsigned zera_q[$];
    int errors = 0;
    int checks = 0;
    int rodada_exp = 0;

    task automatic check(input string nome, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, actual, expected, $time);
        end
    endtask

    // ---------------- Monitor ----------------
    initial begin
        evt_t e;
        logic prev_pulse, prev_fim, prev_zera;
        prev_pulse = 1'b0; prev_fim = 1'b0; prev_zera = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.timeout || bus.no_prazo) begin
                    check("pulso_um_ciclo", int'(prev_pulse), 0);
                    check("pulso_exclusivo", int'(bus.timeout & bus.no_prazo), 0);
                    if (exp_q.size() == 0) begin
                        check("evento_inesperado", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("evento %s cyc=%0d rodada=%0d alerta=%0d q=%0d",
                                 bus.timeout ? "timeout" : "no_prazo", cyc, bus.rodada, bus.alerta, q);
                        check("tipo_evento", bus.timeout ? 1 : 0, e.kind);
                        check("ciclo_evento", int'(cyc), int'(e.cyc));
                        check("rodada", int'(bus.rodada), e.rodada);
                        check("alerta", int'(bus.alerta), e.alerta);
                        check("q_congelado", int'(q), e.q);
                        check("estado_resultado", int'(bus.db_estado), 4);
                    end
                end
                if (bus.fim_jogo && !prev_fim) begin
                    if (exp_q.size() == 0) begin
                        check("fim_inesperado", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("evento fim_jogo cyc=%0d rodada=%0d", cyc, bus.rodada);
                        check("tipo_fim", 2, e.kind);
                        check("ciclo_fim", int'(cyc), int'(e.cyc));
                        check("rodada_fim", int'(bus.rodada), e.rodada);
                        check("estado_fim", int'(bus.db_estado), 5);
                    end
                end
                if (bus.zera_contador) begin
                    check("zera_um_ciclo", int'(prev_zera), 0);
                    if (zera_q.size() == 0) begin
                        check("zera_inesperado", 1, 0);
                    end else begin
                        $display("evento zera cyc=%0d rodada=%0d", cyc, bus.rodada);
                        check("ciclo_zera", int'(cyc), int'(zera_q.pop_front()));
                        check("estado_prepara", int'(bus.db_estado), 1);
                        check("rodada_prepara", int'(bus.rodada), rodada_exp);
                    end
                end
            end
            prev_pulse = bus.timeout | bus.no_prazo;
            prev_fim   = bus.fim_jogo;
            prev_zera  = bus.zera_contador;
        end
    end

    // ---------------- Stimulus ----------------
    task automatic limpa();
        bus.iniciar = 1'b0; bus.pausar = 1'b0;
        bus.resposta_valida = 1'b0; bus.proxima = 1'b0;
    endtask

    // Called at a negedge in INICIAL/FIM_JOGO; returns at the negedge of the
    // first counting cycle.
    task automatic inicia_jogo();
        bus.iniciar = 1'b1;
        rodada_exp = 0;
        zera_q.push_back(cyc + 1);
        @(negedge clock); limpa();
        @(negedge clock);
    endtask

    // One round from its first counting cycle until the outcome is registered.
    task automatic run_round(input int ans_j, input int pj, input int plen);
        int  j;
        bit  done;
        int  q_exp;
        j = 0; done = 1'b0;
        while (!done) begin
            bus.proxima = ($urandom_range(0, 15) == 0);
            bus.iniciar = ($urandom_range(0, 15) == 0);
            if (j == ans_j) begin
                bus.resposta_valida = 1'b1;
                q_exp = ((j + 1) / CLK_DIV > M - 1) ? M - 1 : (j + 1) / CLK_DIV;
                exp_q.push_back('{0, cyc + 1, rodada_exp, (j >= J_MEIO) ? 1 : 0, q_exp});
                done = 1'b1;
            end else if (j == J_FIM) begin
                exp_q.push_back('{1, cyc + 1, rodada_exp, 1, M - 1});
                done = 1'b1;
            end else if (j == pj) begin
                bus.pausar = 1'b1;
                if (PAUSA_ATIVA) begin
                    @(negedge clock); limpa();
                    for (int k = 0; k < plen; k++) begin
                        bus.resposta_valida = (k == plen / 2);
                        bus.pausar          = (k == plen - 1);
                        @(negedge clock); limpa();
                    end
                    j++;
                    continue;
                end
            end
            @(negedge clock); limpa();
            j++;
        end
    endtask

    // Called in RESULTADO: idle a little, then proxima.
    task automatic avanca();
        int espera;
        espera = $urandom_range(0, 2);
        for (int k = 0; k < espera; k++) begin
            bus.iniciar         = ($urandom_range(0, 3) == 0);
            bus.pausar          = ($urandom_range(0, 3) == 0);
            bus.resposta_valida = ($urandom_range(0, 3) == 0);
            @(negedge clock); limpa();
        end
        bus.proxima = 1'b1;
        if (rodada_exp == NUM_RODADAS - 1) begin
            exp_q.push_back('{2, cyc + 1, NUM_RODADAS - 1, 0, 0});
            @(negedge clock); limpa();
        end else begin
            rodada_exp++;
            zera_q.push_back(cyc + 1);
            @(negedge clock); limpa();
            @(negedge clock);
        end
    endtask

    task automatic check_reset_state(input string nome);
        check({nome, "_estado"}, int'(bus.db_estado), 0);
        check({nome, "_rodada"}, int'(bus.rodada), 0);
        check({nome, "_saidas"}, int'({bus.zera_contador, bus.conta_contador, bus.alerta,
                                       bus.timeout, bus.no_prazo, bus.fim_jogo}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ans, pj, plen;
        limpa();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_state("reset_inicial");
        reset = 1'b0;
        @(negedge clock);

        // Directed game: timeout, early answer, answer on the fim cycle.
        inicia_jogo();
        run_round(99, -1, 0);       avanca();
        run_round(8, -1, 0);        avanca();
        run_round(J_FIM, -1, 0);    avanca();
        @(negedge clock);

        // Directed game: long pause at Q=2, tick-edge answer, meio-edge answer.
        inicia_jogo();
        run_round(20, 9, 40);       avanca();
        run_round(3, -1, 0);        avanca();
        run_round(J_MEIO, -1, 0);   avanca();
        @(negedge clock);

        // Reset in the middle of round 1 with alerta already raised.
        inicia_jogo();
        run_round(5, -1, 0);        avanca();
        repeat (14) @(negedge clock);
        check("alerta_antes_reset", int'(bus.alerta), 1);
        reset = 1'b1;
        #1;
        check_reset_state("reset_imediato");
        @(negedge clock);
        check_reset_state("reset_ciclo_seguinte");
        reset = 1'b0;
        @(negedge clock);

        // Randomized games.
        for (int g = 0; g < 12; g++) begin
            inicia_jogo();
            for (int r = 0; r < NUM_RODADAS; r++) begin
                ans  = $urandom_range(0, J_FIM + 6);
                pj   = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, J_FIM - 1);
                plen = $urandom_range(3, 45);
                run_round(ans, pj, plen);
                avanca();
            end
            repeat ($urandom_range(0, 2)) begin
                bus.proxima = 1'b1; bus.resposta_valida = 1'b1;
                @(negedge clock); limpa();
            end
        end

        repeat (5) @(negedge clock);
        check("eventos_pendentes", exp_q.size(), 0);
        check("zera_pendentes", zera_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
